// File: rtl/uart_apb_arbiter.sv
// rtl/uart_apb_arbiter.sv - two-requester APB3 arbiter in front of a UART register file
module uart_apb_arbiter #(
    parameter int APB_ADDR_WIDTH = 32,
    parameter int APB_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      i_apb_pclk,
    input  logic                      i_apb_presetn,

    input  logic [APB_ADDR_WIDTH-1:0] i_s0_paddr,
    input  logic [APB_DATA_WIDTH-1:0] i_s0_pwdata,
    input  logic                      i_s0_pwrite,
    input  logic                      i_s0_psel,
    input  logic                      i_s0_penable,
    output logic [APB_DATA_WIDTH-1:0] o_s0_prdata,
    output logic                      o_s0_pready,
    output logic                      o_s0_pslverr,

    input  logic [APB_ADDR_WIDTH-1:0] i_s1_paddr,
    input  logic [APB_DATA_WIDTH-1:0] i_s1_pwdata,
    input  logic                      i_s1_pwrite,
    input  logic                      i_s1_psel,
    input  logic                      i_s1_penable,
    output logic [APB_DATA_WIDTH-1:0] o_s1_prdata,
    output logic                      o_s1_pready,
    output logic                      o_s1_pslverr,

    output logic [APB_ADDR_WIDTH-1:0] o_m_paddr,
    output logic [APB_DATA_WIDTH-1:0] o_m_pwdata,
    output logic                      o_m_pwrite,
    output logic                      o_m_psel,
    output logic                      o_m_penable,
    input  logic [APB_DATA_WIDTH-1:0] i_m_prdata,
    input  logic                      i_m_pready,
    input  logic                      i_m_pslverr,

    output logic                      o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_e;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e                    state_q;
    logic                      last_grant_q;
    logic [15:0]               wait_cnt_q;
    logic [APB_ADDR_WIDTH-1:0] addr_q;
    logic [APB_DATA_WIDTH-1:0] wdata_q;
    logic                      write_q;
    logic                      psel_q;
    logic                      penable_q;
    logic                      busy_q;
    logic [APB_DATA_WIDTH-1:0] s0_prdata_q;
    logic [APB_DATA_WIDTH-1:0] s1_prdata_q;
    logic                      s0_pready_q;
    logic                      s1_pready_q;
    logic                      s0_pslverr_q;
    logic                      s1_pslverr_q;

    logic                      req_any_d;
    logic                      grant_d;
    logic [APB_ADDR_WIDTH-1:0] addr_d;
    logic [APB_DATA_WIDTH-1:0] wdata_d;
    logic                      write_d;
    logic                      done_d;
    logic [APB_DATA_WIDTH-1:0] resp_data_d;
    logic                      resp_err_d;

    // Requester penable only qualifies its own APB phase; arbitration keys on psel alone.
    logic unused_penable;
    assign unused_penable = i_s0_penable ^ i_s1_penable;

    // Round-robin: on a tie the port that was not granted last wins.
    always_comb begin
        req_any_d = i_s0_psel | i_s1_psel;
        grant_d   = 1'b0;
        if (i_s0_psel && i_s1_psel) begin
            grant_d = ~last_grant_q;
        end else if (i_s1_psel) begin
            grant_d = 1'b1;
        end
        addr_d  = grant_d ? i_s1_paddr  : i_s0_paddr;
        wdata_d = grant_d ? i_s1_pwdata : i_s0_pwdata;
        write_d = grant_d ? i_s1_pwrite : i_s0_pwrite;
    end

    // A timeout completes the access as an error with zero read data.
    always_comb begin
        done_d      = i_m_pready || (wait_cnt_q == WAIT_LAST);
        resp_data_d = i_m_pready ? i_m_prdata  : '0;
        resp_err_d  = i_m_pready ? i_m_pslverr : 1'b1;
    end

    always_ff @(posedge i_apb_pclk or negedge i_apb_presetn) begin
        if (!i_apb_presetn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            wait_cnt_q   <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            busy_q       <= 1'b0;
            s0_prdata_q  <= '0;
            s1_prdata_q  <= '0;
            s0_pready_q  <= 1'b0;
            s1_pready_q  <= 1'b0;
            s0_pslverr_q <= 1'b0;
            s1_pslverr_q <= 1'b0;
        end else begin
            s0_prdata_q  <= '0;
            s1_prdata_q  <= '0;
            s0_pready_q  <= 1'b0;
            s1_pready_q  <= 1'b0;
            s0_pslverr_q <= 1'b0;
            s1_pslverr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_any_d) begin
                        addr_q       <= addr_d;
                        wdata_q      <= wdata_d;
                        write_q      <= write_d;
                        last_grant_q <= grant_d;
                        wait_cnt_q   <= '0;
                        psel_q       <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (done_d) begin
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        addr_q     <= '0;
                        wdata_q    <= '0;
                        write_q    <= 1'b0;
                        wait_cnt_q <= '0;
                        state_q    <= S_RESP;
                        if (last_grant_q) begin
                            s1_pready_q  <= 1'b1;
                            s1_prdata_q  <= resp_data_d;
                            s1_pslverr_q <= resp_err_d;
                        end else begin
                            s0_pready_q  <= 1'b1;
                            s0_prdata_q  <= resp_data_d;
                            s0_pslverr_q <= resp_err_d;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_m_paddr    = addr_q;
    assign o_m_pwdata   = wdata_q;
    assign o_m_pwrite   = write_q;
    assign o_m_psel     = psel_q;
    assign o_m_penable  = penable_q;
    assign o_busy       = busy_q;
    assign o_s0_prdata  = s0_prdata_q;
    assign o_s0_pready  = s0_pready_q;
    assign o_s0_pslverr = s0_pslverr_q;
    assign o_s1_prdata  = s1_prdata_q;
    assign o_s1_pready  = s1_pready_q;
    assign o_s1_pslverr = s1_pslverr_q;

endmodule

// File: tb/tb_uart_apb_arbiter.sv
// tb/tb_uart_apb_arbiter.sv - directed vector bench for uart_apb_arbiter
module tb_uart_apb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s0_paddr = '0, s0_pwdata = '0, s1_paddr = '0, s1_pwdata = '0;
    logic        s0_pwrite = 1'b0, s0_psel = 1'b0, s0_penable = 1'b0;
    logic        s1_pwrite = 1'b0, s1_psel = 1'b0, s1_penable = 1'b0;
    logic [31:0] s0_prdata, s1_prdata, m_paddr, m_pwdata;
    logic        s0_pready, s0_pslverr, s1_pready, s1_pslverr;
    logic        m_pwrite, m_psel, m_penable, busy;
    logic [31:0] m_prdata = '0;
    logic        m_pready = 1'b0, m_pslverr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_apb_arbiter #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_apb_pclk(clk),
        .i_apb_presetn(rst_n),
        .i_s0_paddr(s0_paddr),
        .i_s0_pwdata(s0_pwdata),
        .i_s0_pwrite(s0_pwrite),
        .i_s0_psel(s0_psel),
        .i_s0_penable(s0_penable),
        .o_s0_prdata(s0_prdata),
        .o_s0_pready(s0_pready),
        .o_s0_pslverr(s0_pslverr),
        .i_s1_paddr(s1_paddr),
        .i_s1_pwdata(s1_pwdata),
        .i_s1_pwrite(s1_pwrite),
        .i_s1_psel(s1_psel),
        .i_s1_penable(s1_penable),
        .o_s1_prdata(s1_prdata),
        .o_s1_pready(s1_pready),
        .o_s1_pslverr(s1_pslverr),
        .o_m_paddr(m_paddr),
        .o_m_pwdata(m_pwdata),
        .o_m_pwrite(m_pwrite),
        .o_m_psel(m_psel),
        .o_m_penable(m_penable),
        .i_m_prdata(m_prdata),
        .i_m_pready(m_pready),
        .i_m_pslverr(m_pslverr),
        .o_busy(busy)
    );

    typedef struct {
        bit          port;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
        bit          slverr;
        int          exp_lat;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input bit port, input logic psel, input logic penable,
                             input logic write, input logic [31:0] addr, input logic [31:0] wdata);
        if (!port) begin
            s0_psel = psel; s0_penable = penable; s0_pwrite = write;
            s0_paddr = addr; s0_pwdata = wdata;
        end else begin
            s1_psel = psel; s1_penable = penable; s1_pwrite = write;
            s1_paddr = addr; s1_pwdata = wdata;
        end
    endtask

    task automatic do_xfer(input vec_t v);
        int acc, lat;
        bit got, setup_seen, stable_bad, other_bad;
        logic own_rdy, own_err, oth_rdy, oth_err;
        logic [31:0] own_rd, oth_rd;
        @(negedge clk);
        drive_req(v.port, 1'b1, 1'b0, v.write, v.addr, v.wdata);
        acc = 0; lat = -1; got = 0; setup_seen = 0; stable_bad = 0; other_bad = 0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk);
            drive_req(v.port, 1'b1, 1'b1, v.write, v.addr, v.wdata);
            m_pready = 1'b0; m_prdata = '0; m_pslverr = 1'b0;
            own_rdy = v.port ? s1_pready : s0_pready;
            own_err = v.port ? s1_pslverr : s0_pslverr;
            own_rd  = v.port ? s1_prdata : s0_prdata;
            oth_rdy = v.port ? s0_pready : s1_pready;
            oth_err = v.port ? s0_pslverr : s1_pslverr;
            oth_rd  = v.port ? s0_prdata : s1_prdata;
            if (m_psel && !m_penable && !setup_seen) begin
                setup_seen = 1;
                check("setup_cycle", c, 1);
                check("setup_paddr", m_paddr, v.addr);
                check("setup_pwdata", m_pwdata, v.wdata);
                check("setup_pwrite", m_pwrite, v.write);
                check("setup_busy", busy, 1);
            end
            if (m_psel && m_penable) begin
                if (m_paddr !== v.addr || m_pwdata !== v.wdata || m_pwrite !== v.write)
                    stable_bad = 1;
                if (acc == v.waits) begin
                    m_pready = 1'b1; m_prdata = v.rdata; m_pslverr = v.slverr;
                end
                acc++;
            end
            if (oth_rdy !== 1'b0 || oth_err !== 1'b0 || oth_rd !== 32'h0) other_bad = 1;
            if (own_rdy === 1'b1) begin
                got = 1;
                lat = c;
                check("resp_prdata", own_rd, v.exp_rdata);
                check("resp_pslverr", own_err, v.exp_err);
                check("resp_m_psel_low", {m_psel, m_penable}, 0);
            end
        end
        check("setup_seen", setup_seen, 1);
        check("pready_latency", lat, v.exp_lat);
        check("access_stable", stable_bad, 0);
        check("other_port_quiet", other_bad, 0);
        @(negedge clk);
        drive_req(v.port, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("pready_one_cycle", v.port ? s1_pready : s0_pready, 0);
        check("busy_after", busy, 0);
    endtask

    task automatic dual_round(output int lat0, output int lat1,
                              output logic [31:0] a_first, output logic [31:0] a_second);
        bit d0, d1;
        int nsetup;
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h1);
        drive_req(1'b1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h2);
        lat0 = -1; lat1 = -1; nsetup = 0; a_first = '0; a_second = '0; d0 = 0; d1 = 0;
        for (int c = 1; c <= 30 && !(d0 && d1); c++) begin
            @(negedge clk);
            m_pready = m_psel && m_penable; m_prdata = 32'h0; m_pslverr = 1'b0;
            if (d0) drive_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            else    drive_req(1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h1);
            if (d1) drive_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            else    drive_req(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h2);
            if (m_psel && !m_penable) begin
                if (nsetup == 0) a_first = m_paddr;
                else if (nsetup == 1) a_second = m_paddr;
                nsetup++;
            end
            if (s0_pready && !d0) begin d0 = 1; lat0 = c; end
            if (s1_pready && !d1) begin d1 = 1; lat1 = c; end
        end
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive_req(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        m_pready = 1'b0;
    endtask

    initial begin
        int l0, l1;
        logic [31:0] af, as;
        bit bad;

        // port write addr wdata waits rdata slverr | lat exp_rdata exp_err
        vecs[0] = '{1'b0, 1'b1, 32'h04, 32'hA5, 0,  32'h00, 1'b0, 3, 32'h00, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h08, 32'h11, 3,  32'h5A, 1'b0, 6, 32'h5A, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'h0C, 32'h22, 1,  32'h3C, 1'b1, 4, 32'h3C, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h10, 32'h77, 2,  32'h00, 1'b1, 5, 32'h00, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'h14, 32'h33, 10, 32'hFF, 1'b0, 6, 32'h00, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 32'h18, 32'h00, 10, 32'hEE, 1'b0, 6, 32'h00, 1'b1};

        repeat (3) @(negedge clk);
        check("reset_m_psel", m_psel, 0);
        check("reset_m_paddr", m_paddr, 0);
        check("reset_busy", busy, 0);
        check("reset_s0_pready", s0_pready, 0);
        check("reset_s1_prdata", s1_prdata, 0);
        rst_n = 1'b1;

        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (m_psel !== 1'b0 || busy !== 1'b0 || m_paddr !== 32'h0) bad = 1;
        end
        check("idle_quiet", bad, 0);

        for (int r = 0; r < 2; r++) begin
            dual_round(l0, l1, af, as);
            check("tie_first_addr", af, 32'h100);
            check("tie_second_addr", as, 32'h200);
            check("tie_lat0", l0, 3);
            check("tie_lat1", l1, 7);
        end

        for (int i = 0; i < 6; i++) do_xfer(vecs[i]);

        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h55);
        @(negedge clk);
        drive_req(1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 32'h55);
        @(negedge clk);
        check("rst_pre_access", {m_psel, m_penable}, 3);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_psel", {m_psel, m_penable}, 0);
        check("rst_async_paddr", m_paddr, 0);
        check("rst_async_pwdata", m_pwdata, 0);
        check("rst_async_busy", busy, 0);
        @(negedge clk);
        drive_req(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (s0_pready !== 1'b0 || s1_pready !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        check("rst_no_pulse", bad, 0);
        do_xfer(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/uart_apb_arbiter.md
UART_APB_ARBITER -- requirements
Module: uart_apb_arbiter

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 32, SHALL set the address width of all ports.
REQ-002 Parameter APB_DATA_WIDTH, default 32, SHALL set the data width of all ports.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, range 1..65535, SHALL set the maximum number of master ACCESS cycles before abort.
REQ-004 i_apb_pclk  in  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 i_apb_presetn  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 i_sN_paddr, i_sN_pwdata, i_sN_pwrite, i_sN_psel, i_sN_penable (N=0,1)  in  AW/DW/1/1/1  SHALL be the APB3 slave-port request from requester N.
REQ-007 o_sN_prdata, o_sN_pready, o_sN_pslverr (N=0,1)  out  DW/1/1  SHALL be the APB3 slave-port response to requester N.
REQ-008 o_m_paddr, o_m_pwdata, o_m_pwrite, o_m_psel, o_m_penable  out  AW/DW/1/1/1  SHALL be the APB3 master port toward the UART register file.
REQ-009 i_m_prdata, i_m_pready, i_m_pslverr  in  DW/1/1  SHALL be the UART response.
REQ-010 o_busy  out  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-011 FSM states SHALL be IDLE, SETUP, ACCESS, RESP.
REQ-012 In IDLE, a request from port N is pending when i_sN_psel=1; with none pending, the FSM SHALL stay in IDLE with all master outputs 0.
REQ-013 With one request pending, that port SHALL be granted; with both pending, the port not equal to last_grant SHALL be granted (round-robin).
REQ-014 On grant: paddr/pwdata/pwrite of the granted port SHALL be latched, last_grant updated, and the FSM SHALL move to SETUP.
REQ-015 SETUP: o_m_psel=1, o_m_penable=0, latched values on o_m_paddr/pwdata/pwrite; next state is always ACCESS.
REQ-016 ACCESS: o_m_psel=1, o_m_penable=1; on i_m_pready=1, i_m_prdata and i_m_pslverr SHALL be registered and the FSM SHALL move to RESP.
REQ-017 ACCESS: a wait counter SHALL increment each cycle i_m_pready=0; on reaching TIMEOUT_CYCLES the FSM SHALL move to RESP with registered pslverr=1, prdata=0, and master psel/penable SHALL drop the next cycle.
REQ-018 RESP: o_sN_pready=1 for exactly one cycle on the granted port only, with registered prdata/pslverr; master psel=penable=0; next state IDLE.
REQ-019 Master outputs SHALL hold stable from SETUP through the last ACCESS cycle.
REQ-020 The non-granted port SHALL see o_sN_pready=0, o_sN_pslverr=0 and o_sN_prdata=0 throughout; its request remains pending and is served next.
REQ-021 Minimum latency: requester SETUP at cycle T, grant at T, master SETUP at T+1, master ACCESS at T+2, requester pready at T+3 when i_m_pready=1 at T+2.
REQ-022 If the granted requester drops psel before RESP, the master transfer SHALL complete normally and the response pulse SHALL still be issued (the requester ignores it).
REQ-023 A new grant SHALL NOT be made in RESP; the earliest re-arbitration is the following IDLE cycle, so back-to-back transfers take 4 cycles each with zero wait states.
REQ-024 o_m_pwdata SHALL hold the latched value for reads as well; the UART ignores it.

Reset
REQ-025 On i_apb_presetn=0, asynchronously: FSM=IDLE, last_grant=1 (port 0 wins the first tie), wait counter=0, all latches 0, every output 0.
REQ-026 Reset asserted mid-transfer SHALL abort it silently; no pready pulse SHALL be issued after release.
REQ-027 After release, the first arbitration SHALL occur on the first rising edge with presetn=1.

Verification
REQ-028 Single write on port 0: paddr=0x04, pwdata=0xA5, UART pready=1 on first ACCESS -> master SETUP/ACCESS with 0x04/0xA5, o_s0_pready pulse 3 cycles after s0 SETUP, o_s1_pready stays 0.
REQ-029 Simultaneous requests on both ports after reset -> port 0 served first, then port 1; repeated simultaneous requests alternate 0,1,0,1.
REQ-030 Read on port 1 with 3 UART wait states, i_m_prdata=0x5A -> o_s1_prdata=0x5A, pslverr=0, pready 6 cycles after s1 SETUP.
REQ-031 TIMEOUT_CYCLES=4, UART pready held 0 -> after 4 ACCESS cycles, master psel drops, o_s0_pslverr=1 with pready, prdata=0.
REQ-032 UART i_m_pslverr=1 on completion -> o_sN_pslverr=1 forwarded to the granted port only.
REQ-033 Reset asserted during ACCESS -> all outputs 0 immediately, no response pulse after release, the next request is served normally.
